// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: key codes, ALU op encodings, FSM states.
package calc_pkg;

    typedef logic [4:0] digit_t;

    localparam logic [4:0] KEY_9   = 5'd9;
    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_MUL = 5'd12;
    localparam logic [4:0] KEY_DIV = 5'd13;
    localparam logic [4:0] KEY_POW = 5'd14;
    localparam logic [4:0] KEY_EQ  = 5'd15;
    localparam logic [4:0] KEY_CLR = 5'd16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_POW = 3'b100;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ENT_A  = 3'd1;
    localparam logic [2:0] ST_ENT_OP = 3'd2;
    localparam logic [2:0] ST_ENT_B  = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_SHOW   = 3'd5;

    // Operator keys are contiguous and ordered like the op encodings.
    function automatic logic [2:0] key_to_op(input logic [4:0] key);
        return 3'(key - KEY_ADD);
    endfunction

endpackage

// File: rtl/digit_entry.sv
// Two-digit operand register: load starts a fresh operand, push shifts ones->tens once.
module digit_entry
    import calc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       push_i,
    input  digit_t     digit_i,
    output digit_t     tens_o,
    output digit_t     ones_o,
    output logic [1:0] count_o
);

    digit_t     tens_q, tens_d;
    digit_t     ones_q, ones_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        count_d = count_q;
        if (clear_i) begin
            tens_d  = '0;
            ones_d  = '0;
            count_d = 2'd0;
        end else if (load_i || (push_i && count_q == 2'd0)) begin
            tens_d  = '0;
            ones_d  = digit_i;
            count_d = 2'd1;
        end else if (push_i && count_q == 2'd1) begin
            tens_d  = ones_q;
            ones_d  = digit_i;
            count_d = 2'd2;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tens_q  <= '0;
            ones_q  <= '0;
            count_q <= 2'd0;
        end else begin
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            count_q <= count_d;
        end
    end

    assign tens_o  = tens_q;
    assign ones_o  = ones_q;
    assign count_o = count_q;

endmodule

// File: rtl/calc_seq.sv
// Keypad-driven calculator sequencer: collects A op B, lets the external ALU settle,
// then captures its result digits onto the display.
module calc_seq
    import calc_pkg::*;
#(
    parameter int unsigned ALU_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [9:0] alu_a,
    output logic [9:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [4:0] alu_out1,
    input  logic [4:0] alu_out2,
    input  logic [4:0] alu_out3,
    input  logic [4:0] alu_out4,
    output logic [4:0] disp1,
    output logic [4:0] disp2,
    output logic [4:0] disp3,
    output logic [4:0] disp4,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [3:0][4:0]  disp_q, disp_d;

    logic             a_clr, a_load, a_push;
    logic             b_clr, b_load, b_push;
    digit_t           a_tens, a_ones, b_tens, b_ones;
    logic [1:0]       a_cnt, b_cnt;

    logic is_digit, is_op, is_eq, is_clr;

    assign is_digit = key_valid && (key_code <= KEY_9);
    assign is_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_POW);
    assign is_eq    = key_valid && (key_code == KEY_EQ);
    assign is_clr   = key_valid && (key_code == KEY_CLR);

    digit_entry u_entry_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (a_clr),
        .load_i  (a_load),
        .push_i  (a_push),
        .digit_i (key_code),
        .tens_o  (a_tens),
        .ones_o  (a_ones),
        .count_o (a_cnt)
    );

    digit_entry u_entry_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (b_clr),
        .load_i  (b_load),
        .push_i  (b_push),
        .digit_i (key_code),
        .tens_o  (b_tens),
        .ones_o  (b_ones),
        .count_o (b_cnt)
    );

    // disp_q[0] is disp1 (tens of the operand during entry, thousands of a result).
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        a_clr   = 1'b0;
        a_load  = 1'b0;
        a_push  = 1'b0;
        b_clr   = 1'b0;
        b_load  = 1'b0;
        b_push  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_digit) begin
                    a_load  = 1'b1;
                    disp_d  = {5'd0, 5'd0, key_code, 5'd0};
                    state_d = ST_ENT_A;
                end
            end
            ST_ENT_A: begin
                if (is_digit) begin
                    a_push = 1'b1;
                    if (a_cnt == 2'd1) disp_d = {5'd0, 5'd0, key_code, a_ones};
                end else if (is_op) begin
                    op_d    = key_to_op(key_code);
                    state_d = ST_ENT_OP;
                end
            end
            ST_ENT_OP: begin
                if (is_op) begin
                    op_d = key_to_op(key_code);
                end else if (is_digit) begin
                    b_load  = 1'b1;
                    disp_d  = {5'd0, 5'd0, key_code, 5'd0};
                    state_d = ST_ENT_B;
                end else if (is_eq) begin
                    err_d   = 1'b1;
                    a_clr   = 1'b1;
                    b_clr   = 1'b1;
                    disp_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ENT_B: begin
                if (is_digit) begin
                    b_push = 1'b1;
                    if (b_cnt == 2'd1) disp_d = {5'd0, 5'd0, key_code, b_ones};
                end else if (is_eq) begin
                    cnt_d   = 4'(ALU_WAIT);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    disp_d  = {alu_out4, alu_out3, alu_out2, alu_out1};
                    done_d  = 1'b1;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SHOW: begin
                // The result stays on the display until a digit of the new operand is shifted in.
                if (is_digit) begin
                    a_load  = 1'b1;
                    state_d = ST_ENT_A;
                end else if (is_op) begin
                    op_d    = key_to_op(key_code);
                    state_d = ST_ENT_OP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (is_clr) begin
            state_d = ST_IDLE;
            op_d    = OP_ADD;
            cnt_d   = 4'd0;
            err_d   = 1'b0;
            disp_d  = '0;
            done_d  = 1'b0;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            a_load  = 1'b0;
            a_push  = 1'b0;
            b_load  = 1'b0;
            b_push  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
        end
    end

    assign alu_a  = {a_tens, a_ones};
    assign alu_b  = {b_tens, b_ones};
    assign alu_op = op_q;
    assign disp1  = disp_q[0];
    assign disp2  = disp_q[1];
    assign disp3  = disp_q[2];
    assign disp4  = disp_q[3];
    assign busy   = (state_q == ST_EXEC);
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: directed scenarios plus random keys against a value-level model.
module tb_calc_seq;

    localparam int W = 2;

    localparam int M_IDLE = 0;
    localparam int M_A    = 1;
    localparam int M_OP   = 2;
    localparam int M_B    = 3;
    localparam int M_EXEC = 4;
    localparam int M_SHOW = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [4:0] key_code = 5'd0;
    logic [9:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [4:0] alu_out1, alu_out2, alu_out3, alu_out4;
    logic [4:0] disp1, disp2, disp3, disp4;
    logic       busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: operands as plain integers plus a digit count.
    int m_mode, m_a, m_an, m_b, m_bn, m_op, m_err, m_left, m_done;
    int m_disp[4];

    always #5 clk = ~clk;

    calc_seq #(.ALU_WAIT(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out1  (alu_out1),
        .alu_out2  (alu_out2),
        .alu_out3  (alu_out3),
        .alu_out4  (alu_out4),
        .disp1     (disp1),
        .disp2     (disp2),
        .disp3     (disp3),
        .disp4     (disp4),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    function automatic int alu_ref(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = a + b;
            1: r = (a - b + 10000) % 10000;
            2: r = a * b;
            3: r = (b == 0) ? 9999 : a / b;
            4: begin
                r = 1;
                for (int i = 0; i < b; i++) r = (r * a) % 10000;
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    // Stand-in for alu_m, living above calc_seq.
    always_comb begin
        int r;
        r = alu_ref(int'(alu_a[9:5]) * 10 + int'(alu_a[4:0]),
                    int'(alu_b[9:5]) * 10 + int'(alu_b[4:0]), int'(alu_op));
        alu_out1 = 5'(r / 1000);
        alu_out2 = 5'((r / 100) % 10);
        alu_out3 = 5'((r / 10) % 10);
        alu_out4 = 5'(r % 10);
    end

    function automatic void model_reset();
        m_mode = M_IDLE; m_a = 0; m_an = 0; m_b = 0; m_bn = 0;
        m_op = 0; m_err = 0; m_left = 0; m_done = 0;
        for (int i = 0; i < 4; i++) m_disp[i] = 0;
    endfunction

    function automatic void model_key(input int c);
        if (c <= 9) begin
            case (m_mode)
                M_IDLE: begin
                    m_a = c; m_an = 1; m_mode = M_A;
                    m_disp = '{0, c, 0, 0};
                end
                M_A: if (m_an == 1) begin
                    m_a = m_a * 10 + c; m_an = 2;
                    m_disp = '{m_a / 10, m_a % 10, 0, 0};
                end
                M_OP: begin
                    m_b = c; m_bn = 1; m_mode = M_B;
                    m_disp = '{0, c, 0, 0};
                end
                M_B: if (m_bn == 1) begin
                    m_b = m_b * 10 + c; m_bn = 2;
                    m_disp = '{m_b / 10, m_b % 10, 0, 0};
                end
                M_SHOW: begin
                    m_a = c; m_an = 1; m_mode = M_A;
                end
                default: ;
            endcase
        end else if (c >= 10 && c <= 14) begin
            if (m_mode == M_A || m_mode == M_OP || m_mode == M_SHOW) begin
                m_op = c - 10; m_mode = M_OP;
            end
        end else if (c == 15) begin
            if (m_mode == M_OP) begin
                m_err = 1; m_a = 0; m_an = 0; m_b = 0; m_bn = 0;
                m_disp = '{0, 0, 0, 0};
                m_mode = M_IDLE;
            end else if (m_mode == M_B) begin
                m_mode = M_EXEC; m_left = W;
            end
        end
    endfunction

    function automatic void model_step(input logic v, input logic [4:0] c);
        int r;
        m_done = 0;
        if (v && c == 5'd16) begin
            model_reset();
        end else if (m_mode == M_EXEC) begin
            if (m_left == 0) begin
                r = alu_ref(m_a, m_b, m_op);
                m_disp = '{r / 1000, (r / 100) % 10, (r / 10) % 10, r % 10};
                m_done = 1;
                m_mode = M_SHOW;
            end else begin
                m_left--;
            end
        end else if (v) begin
            model_key(int'(c));
        end
    endfunction

    // One clock: present a key (or none) around the edge and advance the model with it.
    task automatic tick(input logic v, input logic [4:0] c);
        @(negedge clk);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        model_step(v, c);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [4:0] c);
        tick(1'b1, c);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({alu_a, alu_b, alu_op, disp1, disp2, disp3, disp4, busy, done, err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%h disp=%h%h%h%h busy=%b done=%b err=%b required all 0",
                     alu_a, alu_b, alu_op, disp1, disp2, disp3, disp4, busy, done, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        press(5'd5);
        n_checks++;
        if (alu_a !== {5'd0, 5'd5}) begin
            n_errors++;
            $display("FAIL first_key_after_reset: got alu_a=%h required %h", alu_a, {5'd0, 5'd5});
        end
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick(1'b0, 5'd0);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_checks++;
        if (lat != W + 1) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, W + 1);
        end
    endtask

    task automatic test_basic();
        int lat;
        press(5'd16);
        press(5'd5); press(5'd7); press(5'd10); press(5'd2); press(5'd5);
        n_checks++;
        if (alu_a !== {5'd5, 5'd7} || alu_b !== {5'd2, 5'd5} || alu_op !== 3'b000) begin
            n_errors++;
            $display("FAIL basic_operands: got a=%h b=%h op=%h required a=%h b=%h op=0",
                     alu_a, alu_b, alu_op, {5'd5, 5'd7}, {5'd2, 5'd5});
        end
        n_checks++;
        if (disp1 !== 5'd2 || disp2 !== 5'd5 || disp3 !== 5'd0 || disp4 !== 5'd0) begin
            n_errors++;
            $display("FAIL basic_entry_disp: got %0d%0d%0d%0d required 2500", disp1, disp2, disp3, disp4);
        end
        press(5'd15);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_busy: got %b required 1", busy);
        end
        wait_done("basic", lat);
        n_checks++;
        if (disp1 !== 5'd0 || disp2 !== 5'd0 || disp3 !== 5'd8 || disp4 !== 5'd2) begin
            n_errors++;
            $display("FAIL basic_result: got %0d%0d%0d%0d required 0082", disp1, disp2, disp3, disp4);
        end
        tick(1'b0, 5'd0);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_chain();
        int lat;
        press(5'd11); press(5'd1); press(5'd15);
        n_checks++;
        if (alu_op !== 3'b001 || alu_a !== {5'd5, 5'd7} || alu_b !== {5'd0, 5'd1}) begin
            n_errors++;
            $display("FAIL chain_operands: got op=%h a=%h b=%h required op=1 a=%h b=%h",
                     alu_op, alu_a, alu_b, {5'd5, 5'd7}, {5'd0, 5'd1});
        end
        wait_done("chain", lat);
        n_checks++;
        if (disp3 !== 5'd5 || disp4 !== 5'd6 || disp1 !== 5'd0 || disp2 !== 5'd0) begin
            n_errors++;
            $display("FAIL chain_result: got %0d%0d%0d%0d required 0056", disp1, disp2, disp3, disp4);
        end
    endtask

    task automatic test_three_digits();
        press(5'd16);
        press(5'd1); press(5'd2); press(5'd3);
        n_checks++;
        if (alu_a !== {5'd1, 5'd2} || disp1 !== 5'd1 || disp2 !== 5'd2) begin
            n_errors++;
            $display("FAIL three_digits: got a=%h disp=%0d%0d required a=%h disp=12",
                     alu_a, disp1, disp2, {5'd1, 5'd2});
        end
        press(5'd25);
        n_checks++;
        if (alu_a !== {5'd1, 5'd2} || alu_op !== 3'b000) begin
            n_errors++;
            $display("FAIL ignored_key: got a=%h op=%h required a=%h op=0", alu_a, alu_op, {5'd1, 5'd2});
        end
    endtask

    task automatic test_err();
        press(5'd16);
        press(5'd4); press(5'd12); press(5'd15);
        tick(1'b0, 5'd0);
        n_checks++;
        if (err !== 1'b1 || alu_a !== 10'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL err_set: got err=%b a=%h busy=%b required 1 0 0", err, alu_a, busy);
        end
        press(5'd3);
        n_checks++;
        if (alu_a !== {5'd0, 5'd3} || err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_idle_digit: got a=%h err=%b required a=%h err=1", alu_a, err, {5'd0, 5'd3});
        end
        press(5'd16);
        n_checks++;
        if (err !== 1'b0 || alu_a !== 10'd0) begin
            n_errors++;
            $display("FAIL err_clear: got err=%b a=%h required 0 0", err, alu_a);
        end
    endtask

    task automatic test_clear_exec();
        int pulses = 0;
        press(5'd16);
        press(5'd9); press(5'd14); press(5'd3); press(5'd15);
        press(5'd16);
        n_checks++;
        if (busy !== 1'b0 || {disp1, disp2, disp3, disp4} !== 20'd0 || alu_op !== 3'b000) begin
            n_errors++;
            $display("FAIL clear_exec_state: got busy=%b disp=%h op=%h required 0 0 0",
                     busy, {disp1, disp2, disp3, disp4}, alu_op);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 5'd0);
            if (done === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_errors++;
            $display("FAIL clear_exec_no_done: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        press(5'd16);
        press(5'd2); press(5'd12); press(5'd3); press(5'd15);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_op, disp1, disp2, disp3, disp4, busy, done, err} !== '0) begin
            n_errors++;
            $display("FAIL async_reset_outputs: got a=%h b=%h op=%h busy=%b done=%b required all 0",
                     alu_a, alu_b, alu_op, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 5'd0);
            if (done === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset_no_done: got %0d pulses busy=%b required 0 0", pulses, busy);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [4:0] c;
        int         sel;
        logic [9:0] ea, eb;
        logic [19:0] ed;
        press(5'd16);
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 99);
            if (sel < 50)      c = 5'($urandom_range(0, 9));
            else if (sel < 70) c = 5'($urandom_range(10, 14));
            else if (sel < 85) c = 5'd15;
            else if (sel < 88) c = 5'd16;
            else               c = 5'($urandom_range(17, 31));
            tick(v, c);
            ea = {5'(m_a / 10), 5'(m_a % 10)};
            eb = {5'(m_b / 10), 5'(m_b % 10)};
            ed = {5'(m_disp[0]), 5'(m_disp[1]), 5'(m_disp[2]), 5'(m_disp[3])};
            n_checks++;
            if (alu_a !== ea || alu_b !== eb || alu_op !== 3'(m_op)) begin
                n_errors++;
                $display("FAIL rand_operands@%0d: got a=%h b=%h op=%h required a=%h b=%h op=%0d",
                         i, alu_a, alu_b, alu_op, ea, eb, m_op);
            end
            n_checks++;
            if ({disp1, disp2, disp3, disp4} !== ed) begin
                n_errors++;
                $display("FAIL rand_disp@%0d: got %h required %h", i, {disp1, disp2, disp3, disp4}, ed);
            end
            n_checks++;
            if (busy !== (m_mode == M_EXEC) || done !== 1'(m_done) || err !== 1'(m_err)) begin
                n_errors++;
                $display("FAIL rand_flags@%0d: got busy=%b done=%b err=%b required %b %0d %0d",
                         i, busy, done, err, (m_mode == M_EXEC), m_done, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_chain();
        test_three_digits();
        test_err();
        test_clear_exec();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
